range_burst_sender: RTL and testbench

- Transmit end of the go/finish-framed sample stream consumed by the team's range-finding blocks.
- Buffers up to DEPTH samples written by a producer. On a send request it replays the buffered burst, one word per cycle.
- Framing: go is high on the first word, finish is high on the last word.
- Sits between a sample producer (CPU/test sequencer) and any go/finish stream consumer.

---
 rtl/range_burst_sender_pkg.sv | 16 +
 rtl/range_burst_sender_if.sv | 34 +++
 rtl/range_burst_sender_fifo.sv | 76 +++++++
 rtl/range_burst_sender.sv | 127 ++++++++++++
 tb/tb_range_burst_sender.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/range_burst_sender_pkg.sv
// range_pkg: shared types and helpers for the range burst sender.
//   sender_state_t : two-state burst FSM encoding (IDLE, SEND).
//   cnt_width()    : bits needed to hold an occupancy of 0..depth.
package range_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sender_state_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/range_burst_sender_if.sv
// range_burst_sender_if: producer-side and stream-side signals of the sender.
//   wr_data/wr_en : sample push from the producer
//   send          : burst request
//   data_out/go/finish : framed output stream
//   busy/full/empty/count/error : status
// master = producer/consumer side, slave = the sender itself.
interface range_burst_sender_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             send;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             error;

  modport master (
    output wr_data, wr_en, send,
    input  data_out, go, finish, busy, full, empty, count, error
  );

  modport slave (
    input  wr_data, wr_en, send,
    output data_out, go, finish, busy, full, empty, count, error
  );
endinterface

// File: rtl/range_burst_sender_fifo.sv
// range_fifo: circular sample buffer with registered occupancy flags.
//   clock, reset (async active-low)
//   i_push/i_wr_data : write at tail; ignored when full at cycle start
//   i_pop/o_rd_data  : head word is visible combinationally, advanced by i_pop
//   o_count/o_full/o_empty : registered post-edge occupancy
module range_fifo
  import range_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [WIDTH-1:0]            i_wr_data,
  output logic [WIDTH-1:0]            o_rd_data,
  output logic [cnt_width(DEPTH)-1:0] o_count,
  output logic                        o_full,
  output logic                        o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full is judged on the registered flag, so a same-cycle pop never frees a slot.
  assign w_push_ok = i_push & ~r_full;
  assign w_pop_ok  = i_pop & ~r_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = r_full;
  assign o_empty   = r_empty;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers (wrap naturally at power-of-two DEPTH), count and flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end
endmodule

// File: rtl/range_burst_sender.sv
// range_burst_sender: buffers producer samples and replays them as one
// go/finish-framed burst per send request.
//   clock, reset (async active-low)
//   bus (slave modport): wr_data/wr_en push, send request, data_out/go/finish
//   stream, busy/full/empty/count/error status. All outputs are registered.
module range_burst_sender
  import range_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  range_burst_sender_if.slave  bus
);
  localparam int CW = cnt_width(DEPTH);

  sender_state_t    r_state;
  sender_state_t    w_state_nxt;
  logic [CW-1:0]    r_len;
  logic [CW-1:0]    r_rem;
  logic [CW-1:0]    w_len_nxt;
  logic [CW-1:0]    w_rem_nxt;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_go, w_go_nxt;
  logic             r_finish, w_finish_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_error, w_error_nxt;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;

  range_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_push    (bus.wr_en),
    .i_pop     (w_pop),
    .i_wr_data (bus.wr_data),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign bus.data_out = r_data_out;
  assign bus.go       = r_go;
  assign bus.finish   = r_finish;
  assign bus.busy     = r_busy;
  assign bus.error    = r_error;
  assign bus.count    = w_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;

  // Next-state and next-output decode. r_rem counts words still to emit;
  // the burst's first word is the one emitted while r_rem still equals r_len.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_rem_nxt    = r_rem;
    w_pop        = 1'b0;
    w_data_nxt   = '0;
    w_go_nxt     = 1'b0;
    w_finish_nxt = 1'b0;
    w_busy_nxt   = r_busy;
    // A dropped push errors in any state; an empty send only errors in IDLE.
    w_error_nxt  = bus.wr_en & w_full;
    case (r_state)
      IDLE: begin
        w_busy_nxt = 1'b0;
        if (bus.send && !w_empty) begin
          w_state_nxt = SEND;
          w_len_nxt   = w_count;
          w_rem_nxt   = w_count;
          w_busy_nxt  = 1'b1;
        end else if (bus.send) begin
          w_error_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SEND: begin
        w_busy_nxt = 1'b1;
        if (r_rem != '0) begin
          w_pop        = 1'b1;
          w_data_nxt   = w_head;
          w_go_nxt     = (r_rem == r_len);
          w_finish_nxt = (r_rem == CW'(1));
          w_rem_nxt    = r_rem - CW'(1);
        end else begin
          // Cycle after finish: close the burst.
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_rem      <= '0;
      r_data_out <= '0;
      r_go       <= 1'b0;
      r_finish   <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_rem      <= w_rem_nxt;
      r_data_out <= w_data_nxt;
      r_go       <= w_go_nxt;
      r_finish   <= w_finish_nxt;
      r_busy     <= w_busy_nxt;
      r_error    <= w_error_nxt;
    end
  end
endmodule

// File: tb/tb_range_burst_sender.sv
// Self-checking bench for range_burst_sender: directed test-plan scenarios
// followed by random traffic, all compared against a queue-based model.
module tb_range_burst_sender;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  range_burst_sender_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

  range_burst_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: buffer as a queue, burst as "words still owed".
  logic [WIDTH-1:0] mq[$];
  int               m_left;
  bit               m_busy;
  bit               m_first;
  logic [WIDTH-1:0] e_data;
  bit               e_go;
  bit               e_fin;
  bit               e_err;

  function automatic void model_reset();
    mq.delete();
    m_left  = 0;
    m_busy  = 1'b0;
    m_first = 1'b0;
    e_data  = '0;
    e_go    = 1'b0;
    e_fin   = 1'b0;
    e_err   = 1'b0;
  endfunction

  function automatic void model_step(input bit we, input logic [WIDTH-1:0] wd, input bit sd);
    bit was_full;
    was_full = (mq.size() == DEPTH);
    e_err  = (we && was_full) || (!m_busy && sd && mq.size() == 0);
    e_data = '0;
    e_go   = 1'b0;
    e_fin  = 1'b0;
    if (!m_busy) begin
      if (sd && mq.size() > 0) begin
        m_busy  = 1'b1;
        m_left  = mq.size();
        m_first = 1'b1;
      end
    end else if (m_left > 0) begin
      e_data  = mq.pop_front();
      e_go    = m_first;
      m_first = 1'b0;
      e_fin   = (m_left == 1);
      m_left--;
    end else begin
      m_busy = 1'b0;
    end
    if (we && !was_full) mq.push_back(wd);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_model();
    chk("data_out", 32'(bif.data_out), 32'(e_data));
    chk("go",       32'(bif.go),       32'(e_go));
    chk("finish",   32'(bif.finish),   32'(e_fin));
    chk("busy",     32'(bif.busy),     32'(m_busy));
    chk("count",    32'(bif.count),    32'(mq.size()));
    chk("full",     32'(bif.full),     32'(mq.size() == DEPTH));
    chk("empty",    32'(bif.empty),    32'(mq.size() == 0));
    chk("error",    32'(bif.error),    32'(e_err));
  endtask

  // One clock: drive inputs, advance model at the edge, compare at negedge.
  task automatic cyc(input bit we, input logic [WIDTH-1:0] wd, input bit sd);
    bif.wr_en   = we;
    bif.wr_data = wd;
    bif.send    = sd;
    @(posedge clock);
    model_step(we, wd, sd);
    @(negedge clock);
    chk_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    bif.wr_en   = 1'b0;
    bif.wr_data = '0;
    bif.send    = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy",  32'(bif.busy),  32'd0);
    chk("rst_empty", 32'(bif.empty), 32'd1);
    chk("rst_count", 32'(bif.count), 32'd0);
    chk("rst_data",  32'(bif.data_out), 32'd0);
    reset = 1'b1;

    // Three-word burst.
    cyc(1'b1, 16'h0003, 1'b0);
    cyc(1'b1, 16'h0009, 1'b0);
    cyc(1'b1, 16'h0005, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("tp1_busy_t", 32'(bif.busy), 32'd1);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("tp1_go", 32'(bif.go), 32'd1);
    chk("tp1_w0", 32'(bif.data_out), 32'h3);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("tp1_w1", 32'(bif.data_out), 32'h9);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("tp1_w2", 32'(bif.data_out), 32'h5);
    chk("tp1_fin", 32'(bif.finish), 32'd1);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("tp1_done_busy", 32'(bif.busy), 32'd0);
    chk("tp1_done_empty", 32'(bif.empty), 32'd1);

    // Single-word burst.
    cyc(1'b1, 16'h00AA, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("tp2_gofin", 32'({bif.go, bif.finish}), 32'h3);
    chk("tp2_data", 32'(bif.data_out), 32'hAA);
    idle(3);

    // Overflow then full burst.
    for (int i = 1; i <= 8; i++) cyc(1'b1, WIDTH'(i), 1'b0);
    cyc(1'b1, 16'h0009, 1'b0);
    chk("tp3_err", 32'(bif.error), 32'd1);
    chk("tp3_count", 32'(bif.count), 32'd8);
    idle(1);
    cyc(1'b0, 16'h0000, 1'b1);
    idle(10);

    // Empty send.
    cyc(1'b0, 16'h0000, 1'b1);
    chk("tp4_err", 32'(bif.error), 32'd1);
    idle(5);

    // Pushes during a burst stay buffered.
    cyc(1'b1, 16'h0010, 1'b0);
    cyc(1'b1, 16'h0020, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, WIDTH'(16'h0030 + i), 1'b0);
    idle(1);
    chk("tp5_count", 32'(bif.count), 32'd7);
    cyc(1'b0, 16'h0000, 1'b1);
    idle(9);

    // Asynchronous reset mid-burst.
    cyc(1'b1, 16'h0001, 1'b0);
    cyc(1'b1, 16'h0002, 1'b0);
    cyc(1'b1, 16'h0003, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_go",    32'(bif.go),       32'd0);
    chk("arst_fin",   32'(bif.finish),   32'd0);
    chk("arst_busy",  32'(bif.busy),     32'd0);
    chk("arst_data",  32'(bif.data_out), 32'd0);
    chk("arst_count", 32'(bif.count),    32'd0);
    chk("arst_empty", 32'(bif.empty),    32'd1);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cyc(1'b0, 16'h0000, 1'b1);
    chk("arst_send_err", 32'(bif.error), 32'd1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 6), WIDTH'($urandom), ($urandom_range(0, 9) < 2));
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
